// File: rtl/mac_pe_if.sv
// Purpose : bundles every per-PE data, qualifier and weight-chain signal of mac_pe.
// Latency : n/a (wires only).
// Backpressure: none; all fields are plain flow-through signals, no handshake.
//
// Modports:
//   master - the driving side (loader, west/north neighbour, testbench):
//            drives w_load, w_in, w_swap, a_in, a_valid_in, p_in and observes the outputs.
//   slave  - the PE itself: consumes the inputs above, drives w_out, a_out,
//            a_valid_out, p_out, p_valid_out.
interface mac_pe_if #(
    parameter int D_W = 8,
    parameter int A_W = 24
);
    // weight chain (north -> south)
    logic           w_load;
    logic [D_W-1:0] w_in;
    logic [D_W-1:0] w_out;
    logic           w_swap;

    // activation path (west -> east)
    logic [D_W-1:0] a_in;
    logic           a_valid_in;
    logic [D_W-1:0] a_out;
    logic           a_valid_out;

    // partial-sum path (north -> south)
    logic [A_W-1:0] p_in;
    logic [A_W-1:0] p_out;
    logic           p_valid_out;

    modport master (
        output w_load, w_in, w_swap, a_in, a_valid_in, p_in,
        input  w_out, a_out, a_valid_out, p_out, p_valid_out
    );

    modport slave (
        input  w_load, w_in, w_swap, a_in, a_valid_in, p_in,
        output w_out, a_out, a_valid_out, p_out, p_valid_out
    );
endinterface

// File: rtl/mac_pe.sv
// Purpose : weight-stationary MAC processing element with double-buffered weight and east/south forwarding.
// Latency : a_in/p_in -> p_out is 1+PIPE cycles; a_in -> a_out and w_in -> w_out are 1 cycle.
// Backpressure: none; the PE accepts a new operand every cycle and never stalls.
//
// Ports:
//   clk  - rising-edge clock.
//   rst  - asynchronous, active-low reset; clears every register immediately.
//   pe   - mac_pe_if.slave: w_load/w_in/w_swap/w_out weight chain, a_in/a_valid_in ->
//          a_out/a_valid_out activation forwarding, p_in -> p_out/p_valid_out partial sum.
// Parameters: D_W operand width, A_W sum width (>= 2*D_W), SIGNED (1 = two's complement),
//             PIPE (1 = registered multiplier stage).
// Optional macro MAC_SAT_EN: when defined the accumulation saturates instead of wrapping.
module mac_pe #(
    parameter int D_W    = 8,
    parameter int A_W    = 24,
    parameter int SIGNED = 0,
    parameter int PIPE   = 1
) (
    input  logic    clk,
    input  logic    rst,
    mac_pe_if.slave pe
);

    localparam int P_W = 2 * D_W;   // exact product width
    localparam int X_W = A_W - P_W; // extension bits from product to sum width

    // The sum must hold any single product without loss.
    generate
        if (A_W < P_W) begin : g_bad_aw
            $error("mac_pe: A_W (%0d) must be >= 2*D_W (%0d)", A_W, P_W);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Weight double buffer and activation forwarding
    // ------------------------------------------------------------------
    logic [D_W-1:0] w_shadow;
    logic [D_W-1:0] w_act;
    logic [D_W-1:0] a_q;
    logic           a_v_q;

    // w_act samples the pre-edge w_shadow, so a load and a swap on the same
    // edge move the old shadow into w_act while the new weight enters the shadow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_shadow <= '0;
            w_act    <= '0;
            a_q      <= '0;
            a_v_q    <= 1'b0;
        end else begin
            if (pe.w_load) begin
                w_shadow <= pe.w_in;
            end
            if (pe.w_swap) begin
                w_act <= w_shadow;
            end
            // forwarded every edge regardless of valid
            a_q   <= pe.a_in;
            a_v_q <= pe.a_valid_in;
        end
    end

    assign pe.w_out       = w_shadow;
    assign pe.a_out       = a_q;
    assign pe.a_valid_out = a_v_q;

    // ------------------------------------------------------------------
    // Multiplier
    // ------------------------------------------------------------------
    // Operands are extended to the full product width first; the low P_W bits
    // of that product are then correct for both signed and unsigned modes,
    // so one unsigned multiplier covers both.
    logic           a_msb;
    logic           w_msb;
    logic [P_W-1:0] a_x;
    logic [P_W-1:0] w_x;
    logic [P_W-1:0] prod_n;
    logic [A_W-1:0] prod_ext;

    assign a_msb  = (SIGNED != 0) & pe.a_in[D_W-1];
    assign w_msb  = (SIGNED != 0) & w_act[D_W-1];
    assign a_x    = {{D_W{a_msb}}, pe.a_in};
    assign w_x    = {{D_W{w_msb}}, w_act};
    assign prod_n = a_x * w_x;

    generate
        if (X_W > 0) begin : g_ext
            logic p_msb;
            assign p_msb    = (SIGNED != 0) & prod_n[P_W-1];
            assign prod_ext = {{X_W{p_msb}}, prod_n};
        end else begin : g_noext
            assign prod_ext = prod_n;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Optional product stage: s_* are the operands seen by the accumulator
    // ------------------------------------------------------------------
    logic [A_W-1:0] s_prod;
    logic [A_W-1:0] s_p;
    logic           s_v;

    generate
        if (PIPE != 0) begin : g_pipe
            logic [A_W-1:0] prod_d;
            logic [A_W-1:0] p_in_d;
            logic           v_d;

            // p_in is delayed alongside the product so the column stays aligned;
            // a reset drops whatever product was in flight.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    prod_d <= '0;
                    p_in_d <= '0;
                    v_d    <= 1'b0;
                end else begin
                    prod_d <= prod_ext;
                    p_in_d <= pe.p_in;
                    v_d    <= pe.a_valid_in;
                end
            end

            assign s_prod = prod_d;
            assign s_p    = p_in_d;
            assign s_v    = v_d;
        end else begin : g_comb
            assign s_prod = prod_ext;
            assign s_p    = pe.p_in;
            assign s_v    = pe.a_valid_in;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Accumulate: invalid cycles pass the north sum through untouched
    // ------------------------------------------------------------------
    logic [A_W-1:0] addend;
    logic [A_W-1:0] sum_n;

    assign addend = s_v ? s_prod : '0;

`ifdef MAC_SAT_EN
    // Overflow is judged on an A_W+1-bit sum: in signed mode a carry-out that
    // disagrees with the result sign bit means overflow, and the carry bit
    // gives the direction; in unsigned mode any carry-out clamps high.
    logic           p_sx;
    logic           a_sx;
    logic [A_W:0]   sum_w;

    assign p_sx  = (SIGNED != 0) & s_p[A_W-1];
    assign a_sx  = (SIGNED != 0) & addend[A_W-1];
    assign sum_w = {p_sx, s_p} + {a_sx, addend};

    always_comb begin
        sum_n = sum_w[A_W-1:0];
        if (SIGNED != 0) begin
            if (sum_w[A_W] != sum_w[A_W-1]) begin
                sum_n = sum_w[A_W] ? {1'b1, {(A_W-1){1'b0}}}
                                   : {1'b0, {(A_W-1){1'b1}}};
            end
        end else if (sum_w[A_W]) begin
            sum_n = '1;
        end
    end
`else
    // plain modulo-2^A_W accumulation
    assign sum_n = s_p + addend;
`endif

    logic [A_W-1:0] p_q;
    logic           p_v_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q   <= '0;
            p_v_q <= 1'b0;
        end else begin
            p_q   <= sum_n;
            p_v_q <= s_v;
        end
    end

    assign pe.p_out       = p_q;
    assign pe.p_valid_out = p_v_q;

endmodule

// File: doc/mac_pe.md
Name: mac_pe

Overview:
- Parametrised weight-stationary processing element; successor to the single-cycle MAC cell.
- Adds a double-buffered weight register with a north→south load chain and activation forwarding to the east.
- Adds valid tracking, an optional multiplier pipeline stage, signed/unsigned mode, and optional saturation.
- Tiles directly into an R×C systolic array; no glue logic between neighbouring PEs.

Parameters:
- D_W, 8: activation/weight width.
- A_W, 24: partial-sum width. Must satisfy A_W >= 2*D_W; violation is an elaboration error.
- SIGNED, 0: 1 = two's-complement operands, 0 = unsigned.
- PIPE, 1: 1 = registered multiplier stage (latency 2); 0 = single stage (latency 1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- w_load  in  1  shift w_in into the shadow weight register.
- w_in  in  D_W  weight chain input, from the north PE or loader.
- w_out  out  D_W  shadow weight, to the south PE's w_in.
- w_swap  in  1  copy the shadow weight into the active weight.
- a_in  in  D_W  activation, from the west.
- a_valid_in  in  1  a_in qualifier.
- a_out  out  D_W  activation, forwarded east.
- a_valid_out  out  1  forwarded qualifier.
- p_in  in  A_W  partial sum, from the north.
- p_out  out  A_W  partial sum, to the south.
- p_valid_out  out  1  p_out qualifier.

Behaviour:
- Reset (rst low, asynchronous):
  - Clears w_shadow, w_act, a_out, a_valid_out, p_out, p_valid_out and all pipeline registers to 0.
  - Takes effect immediately, mid-operation included; in-flight products are discarded.
  - The first edge after deassertion behaves as normal operation.
- Weight chain:
  - On each edge with w_load=1: w_shadow <= w_in.
  - w_out = w_shadow (registered), so a column of R PEs loads in R cycles with weights entered bottom-first.
  - w_load=0: w_shadow holds.
- Weight swap:
  - On each edge with w_swap=1: w_act <= w_shadow.
  - w_load and w_swap in the same cycle: w_act takes the pre-edge w_shadow; w_shadow takes w_in.
  - Loading the shadow never disturbs w_act; compute continues during a reload.
- Forwarding: every edge, a_out <= a_in and a_valid_out <= a_valid_in, regardless of valid. Latency is 1.
- Product operand: the multiply uses the w_act value present at the edge that samples a_in. A swap on that same edge does not affect that product; the new weight applies from the next sample.
- Product extension:
  - SIGNED=1: a_in × w_act as signed, sign-extended to A_W.
  - SIGNED=0: unsigned, zero-extended.
- Pipeline, PIPE=1:
  - Stage 1 registers prod, p_in and a_valid_in.
  - Stage 2 produces p_out <= p_in_d + (v_d ? prod : 0) and p_valid_out <= v_d.
  - Latency from a_in/p_in to p_out is 2.
- Pipeline, PIPE=0: p_out <= p_in + (a_valid_in ? product : 0) and p_valid_out <= a_valid_in. Latency is 1.
- Invalid cycles: p_in passes through unmodified, so bubbles in the skewed array leave the north sums intact.
- Overflow: the addition wraps modulo 2^A_W unless MAC_SAT_EN is defined.
- Upstream skew: p_in from a PIPE=1 neighbour arrives 2 cycles after its a_in. The array skews activations by 1+PIPE per row; that skew is the array's responsibility.

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined, SIGNED=1: the sum clamps to [-2^(A_W-1), 2^(A_W-1)-1].
- Defined, SIGNED=0: the sum clamps to 2^A_W-1.
- Overflow is detected on the full A_W+1-bit sum.
- Not defined: plain A_W-bit wrap; no extra logic.

Test Plan:
- Reset and weight load:
  - Stimulus: assert rst low mid-stream with p_out=0x000123.
  - Required: p_out, p_valid_out, a_out and w_out read 0 before the next edge.
  - Stimulus: after release, w_load=1, w_in=0x05, then w_swap=1, a_in=3, valid, p_in=10.
  - Required: p_out=25, p_valid_out=1, exactly 2 cycles after the a_in sample (PIPE=1).
- Shadow independence:
  - Stimulus: w_act=2. Load w_in=7 over 3 cycles while streaming a_in=1,2,3 with p_in=0.
  - Required: outputs 2, 4, 6.
  - Stimulus: swap, then a_in=1.
  - Required: output 7.
- Simultaneous load and swap:
  - Stimulus: w_shadow=4, then w_load=1, w_in=9, w_swap=1 on the same edge.
  - Required: w_act=4, w_out=9.
- Bubble pass-through:
  - Stimulus: a_valid_in=0, a_in=0xFF, p_in=1000.
  - Required: p_out=1000, p_valid_out=0; a_out=0xFF and a_valid_out=0 one cycle later.
- Signed wrap (SIGNED=1, A_W=16, no macro):
  - Stimulus: p_in=0x7FF0, a_in=4, w=8.
  - Required: p_out=0x8010.
  - Stimulus: a_in=-128 (0x80), w=127, p_in=0.
  - Required: p_out=0xC080 (-16256).
- Saturation (MAC_SAT_EN, SIGNED=0, A_W=16):
  - Stimulus: p_in=0xFFF0, a_in=255, w=255.
  - Required: p_out=0xFFFF.
  - Stimulus: same with SIGNED=1, p_in=0x7FF0, a_in=4, w=8.
  - Required: p_out=0x7FFF.
